// File: rtl/pair_stream_pkg.sv
// Shared definitions for the 00/11 pair-stream transmitter and the detector benches.
// Holds the FSM state encodings and the pair_mark rule.
package pair_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_GAP   = 2'b10
    } state_t;

    // Lowest bit index that can carry a pair mark; bit 0 has no in-frame predecessor.
    localparam int unsigned PAIR_FIRST_BIT = 1;

    function automatic logic pair_match(input logic cur_bit, input logic prev_bit);
        return (cur_bit == prev_bit);
    endfunction

endpackage

// File: rtl/pair_stream_tx_piso.sv
// Parallel-load, shift-right register; q0 is the next bit to transmit.
module piso_shift_reg
    import pair_stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q0
);

    logic [WIDTH-1:0] shreg_r;

    // Shift register: load has priority over shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_r <= {WIDTH{1'b0}};
        end else if (load) begin
            shreg_r <= d;
        end else if (shift) begin
            shreg_r <= {1'b0, shreg_r[WIDTH-1:1]};
        end else begin
            shreg_r <= shreg_r;
        end
    end

    assign q0 = shreg_r[0];

endmodule

// File: rtl/pair_stream_tx.sv
// LSB-first serial transmitter with programmable inter-frame gap and a golden
// pair_mark flag. Moore FSM: every output is decoded from state and registers.
module pair_stream_tx
    import pair_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             pair_mark
);

    localparam int BW = $clog2(WIDTH);
    // A zero-length gap still needs a one-bit counter to keep the vector legal.
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    state_t          state_r;
    state_t          state_s;
    logic [BW-1:0]   bitcnt_r;
    logic [GW-1:0]   gapcnt_r;
    logic            prev_bit_r;
    logic            q0_s;
    logic            load_s;
    logic            shift_s;
    logic            last_bit_s;
    logic            gap_done_s;

    assign load_s     = (state_r == ST_IDLE) && data_valid;
    assign shift_s    = (state_r == ST_SHIFT);
    assign last_bit_s = (bitcnt_r == BW'(WIDTH - 1));
    assign gap_done_s = (gapcnt_r == GW'((GAP > 0) ? (GAP - 1) : 0));

    piso_shift_reg #(.WIDTH(WIDTH)) u_piso (
        .clk   (clk),
        .reset (reset),
        .load  (load_s),
        .shift (shift_s),
        .d     (data_in),
        .q0    (q0_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; the unused encoding falls back to IDLE.
    always_comb begin
        state_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (data_valid) state_s = ST_SHIFT;
                else            state_s = ST_IDLE;
            end
            ST_SHIFT: begin
                if (last_bit_s) state_s = (GAP > 0) ? ST_GAP : ST_IDLE;
                else            state_s = ST_SHIFT;
            end
            ST_GAP: begin
                if (gap_done_s) state_s = ST_IDLE;
                else            state_s = ST_GAP;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Bit/gap counters and the in-frame history bit used for pair_mark.
    always_ff @(posedge clk) begin
        if (reset) begin
            bitcnt_r   <= {BW{1'b0}};
            gapcnt_r   <= {GW{1'b0}};
            prev_bit_r <= 1'b0;
        end else begin
            if (load_s) begin
                bitcnt_r <= {BW{1'b0}};
            end else if (shift_s) begin
                bitcnt_r <= last_bit_s ? {BW{1'b0}} : bitcnt_r + BW'(1);
            end else begin
                bitcnt_r <= bitcnt_r;
            end

            if (state_r == ST_GAP) begin
                gapcnt_r <= gap_done_s ? {GW{1'b0}} : gapcnt_r + GW'(1);
            end else begin
                gapcnt_r <= {GW{1'b0}};
            end

            prev_bit_r <= shift_s ? q0_s : 1'b0;
        end
    end

    // Moore output decode.
    always_comb begin
        data_ready  = 1'b0;
        ser_out     = 1'b0;
        ser_valid   = 1'b0;
        frame_start = 1'b0;
        busy        = 1'b0;
        pair_mark   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                data_ready = 1'b1;
            end
            ST_SHIFT: begin
                ser_valid   = 1'b1;
                ser_out     = q0_s;
                busy        = 1'b1;
                frame_start = (bitcnt_r == {BW{1'b0}});
                pair_mark   = (bitcnt_r >= BW'(PAIR_FIRST_BIT)) && pair_match(q0_s, prev_bit_r);
            end
            ST_GAP: begin
                busy = 1'b1;
            end
            default: begin
                data_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pair_stream_tx.sv
// Self-checking bench: two transmitters (GAP=2 and GAP=0) share the same stimulus;
// expected streams are computed from each word's bits and the gap length.
module tb_pair_stream_tx;

    localparam int W = 8;
    localparam logic [5:0] IDLE_V = 6'b100000; // {ready,ser_out,ser_valid,frame_start,busy,pair_mark}
    localparam logic [5:0] GAP_V  = 6'b000010;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       data_valid = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic rdy2, so2, sv2, fs2, bz2, pm2;
    logic rdy0, so0, sv0, fs0, bz0, pm0;
    logic [5:0] obs;
    bit   sel = 1'b0;
    int   gap_n = 2;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pair_stream_tx #(.WIDTH(W), .GAP(2)) u_dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(rdy2), .ser_out(so2), .ser_valid(sv2), .frame_start(fs2),
        .busy(bz2), .pair_mark(pm2)
    );

    pair_stream_tx #(.WIDTH(W), .GAP(0)) u_dut0 (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(rdy0), .ser_out(so0), .ser_valid(sv0), .frame_start(fs0),
        .busy(bz0), .pair_mark(pm0)
    );

    always_comb obs = sel ? {rdy0, so0, sv0, fs0, bz0, pm0} : {rdy2, so2, sv2, fs2, bz2, pm2};

    // Expected outputs while bit i of word w is on the line.
    function automatic logic [5:0] bit_vec(input logic [7:0] w, input int i);
        logic pm;
        pm = 1'b0;
        if (i > 0) pm = (w[i] == w[i-1]);
        return {1'b0, w[i], 1'b1, (i == 0), 1'b1, pm};
    endfunction

    // Starts in an IDLE cycle (sampled at negedge), sends w, checks every bit and gap cycle.
    task automatic run_frame(input logic [7:0] w, input bit hold_valid, input bit noise);
        checks++;
        if (obs !== IDLE_V) begin
            failures++;
            $display("FAIL idle_before w=%h got=%b exp=%b", w, obs, IDLE_V);
        end
        data_in = w;
        data_valid = 1'b1;
        @(negedge clk);
        if (!hold_valid) data_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            checks++;
            if (obs !== bit_vec(w, i)) begin
                failures++;
                $display("FAIL bit w=%h i=%0d got=%b exp=%b", w, i, obs, bit_vec(w, i));
            end
            if (noise) begin
                data_in = 8'($urandom);
                data_valid = 1'b1;
            end
            @(negedge clk);
        end
        for (int g = 0; g < gap_n; g++) begin
            checks++;
            if (obs !== GAP_V) begin
                failures++;
                $display("FAIL gap w=%h g=%0d got=%b exp=%b", w, g, obs, GAP_V);
            end
            @(negedge clk);
        end
        if (noise) data_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        data_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== IDLE_V) begin
                failures++;
                $display("FAIL reset_idle c=%0d got=%b exp=%b", c, obs, IDLE_V);
            end
        end
        reset = 1'b1;
        data_valid = 1'b1;
        data_in = 8'hFF;
        @(negedge clk);
        reset = 1'b0;
        data_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== IDLE_V) begin
            failures++;
            $display("FAIL reset_vs_valid got=%b exp=%b", obs, IDLE_V);
        end
    endtask

    task automatic test_single_a5();
        run_frame(8'hA5, 1'b0, 1'b0);
        checks++;
        if (obs !== IDLE_V) begin
            failures++;
            $display("FAIL ready_after_a5 got=%b exp=%b", obs, IDLE_V);
        end
    endtask

    task automatic test_back_to_back();
        run_frame(8'hF0, 1'b1, 1'b0);
        run_frame(8'h0F, 1'b1, 1'b0);
        data_valid = 1'b0;
    endtask

    task automatic test_busy_ignore();
        run_frame(8'h96, 1'b0, 1'b1);
        run_frame(8'h3C, 1'b0, 1'b0);
    endtask

    task automatic test_reset_midframe();
        data_in = 8'hFF;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs !== bit_vec(8'hFF, i)) begin
                failures++;
                $display("FAIL abort_bit i=%0d got=%b exp=%b", i, obs, bit_vec(8'hFF, i));
            end
            if (i == 3) reset = 1'b1;
            @(negedge clk);
        end
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (obs !== IDLE_V) begin
                failures++;
                $display("FAIL abort_idle c=%0d got=%b exp=%b", c, obs, IDLE_V);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random(input int n);
        for (int k = 0; k < n; k++) begin
            run_frame(8'($urandom), 1'($urandom), 1'($urandom));
        end
        data_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== IDLE_V) begin
            failures++;
            $display("FAIL random_end got=%b exp=%b", obs, IDLE_V);
        end
    endtask

    task automatic test_gap0();
        sel = 1'b1;
        gap_n = 0;
        test_reset();
        run_frame(8'h55, 1'b1, 1'b0);
        run_frame(8'hAA, 1'b1, 1'b0);
        data_valid = 1'b0;
        test_random(12);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_busy_ignore();
        test_reset_midframe();
        test_random(20);
        test_gap0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
